// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory and the decode stage.
// Valid/ready: a transfer happens on a rising edge where both valid and ready are high;
// the producer holds valid and its payload steady until that edge. imem responses have no ready.
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_resp_valid;
    logic [31:0]       imem_resp_data;
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;

    modport master (
        output imem_req_valid,
        output imem_addr,
        output instr_valid,
        output instr,
        output instr_pc,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data,
        input  instr_ready,
        input  redirect_valid,
        input  redirect_pc
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        input  instr_valid,
        input  instr,
        input  instr_pc,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data,
        output instr_ready,
        output redirect_valid,
        output redirect_pc
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: credit-limited in-order requests to imem, a prefetch FIFO
// toward decode, and a redirect path that drops buffered and in-flight words.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                   CLK,
    input  logic                   RESET,
    instr_fetch_unit_if.master     bus,
    output logic [1:0]             dbg_state_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CW-1:0]     fifo_count_q, fifo_count_d;
    logic [CW-1:0]     outstanding_q, outstanding_d;
    logic [CW-1:0]     discard_q, discard_d;
    logic [PW-1:0]     fifo_wr_q, fifo_rd_q;
    logic [PW-1:0]     pcq_wr_q, pcq_rd_q;

    logic [31:0]       fifo_data_q [DEPTH];
    logic [ADDR_W-1:0] fifo_pc_q   [DEPTH];
    logic [ADDR_W-1:0] pcq_q       [DEPTH];

    logic credit_ok;
    logic req_valid;
    logic req_fire;
    logic resp_in;
    logic push;
    logic pop;
    logic head_valid;
    logic redirect;

    // Buffered plus in-flight words never exceed DEPTH, so every response has a FIFO slot.
    assign credit_ok  = ({1'b0, fifo_count_q} + {1'b0, outstanding_q}) < DEPTH_C;
    assign req_valid  = (state_q == ST_FETCH) && credit_ok;
    assign req_fire   = req_valid && bus.imem_req_ready;
    assign resp_in    = bus.imem_resp_valid;
    assign redirect   = bus.redirect_valid;
    assign head_valid = (fifo_count_q != '0);
    assign pop        = head_valid && bus.instr_ready;
    assign push       = resp_in && (state_q == ST_FETCH) && !redirect;

    assign outstanding_d = outstanding_q + CW'(req_fire) - CW'(resp_in);

    always_comb begin
        fifo_count_d = fifo_count_q;
        if (redirect) begin
            fifo_count_d = '0;
        end else begin
            fifo_count_d = fifo_count_q + CW'(push) - CW'(pop);
        end
    end

    // On redirect everything still owed by memory becomes stale, including this cycle's accept.
    always_comb begin
        discard_d = discard_q;
        if (redirect) begin
            discard_d = outstanding_d;
        end else if (state_q != ST_FLUSH) begin
            discard_d = '0;
        end else if (resp_in && discard_q != '0) begin
            discard_d = discard_q - CW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT:  state_d = ST_FETCH;
            ST_FETCH: state_d = ST_FETCH;
            ST_FLUSH: begin
                if (discard_q == '0 || (resp_in && discard_q == CW'(1))) begin
                    state_d = ST_FETCH;
                end
            end
            default:  state_d = ST_BOOT;
        endcase
        if (redirect) begin
            state_d = (outstanding_d != '0) ? ST_FLUSH : ST_FETCH;
        end
    end

    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = bus.redirect_pc & ~ADDR_W'(3);
        end else if (req_fire) begin
            pc_d = pc_q + ADDR_W'(4);
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            fifo_count_q  <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            fifo_wr_q     <= '0;
            fifo_rd_q     <= '0;
            pcq_wr_q      <= '0;
            pcq_rd_q      <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fifo_count_q  <= fifo_count_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            if (redirect) begin
                fifo_wr_q <= '0;
                fifo_rd_q <= '0;
                pcq_wr_q  <= '0;
                pcq_rd_q  <= '0;
            end else begin
                if (push) begin
                    fifo_wr_q <= fifo_wr_q + PW'(1);
                    pcq_rd_q  <= pcq_rd_q + PW'(1);
                end
                if (pop) begin
                    fifo_rd_q <= fifo_rd_q + PW'(1);
                end
                if (req_fire) begin
                    pcq_wr_q <= pcq_wr_q + PW'(1);
                end
            end
        end
    end

    // Storage needs no reset: occupancy is tracked by the counters and pointers above.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_data_q[fifo_wr_q] <= bus.imem_resp_data;
            fifo_pc_q[fifo_wr_q]   <= pcq_q[pcq_rd_q];
        end
        if (req_fire && !redirect) begin
            pcq_q[pcq_wr_q] <= pc_q;
        end
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_addr      = pc_q;
    assign bus.instr_valid    = head_valid;
    assign bus.instr          = head_valid ? fifo_data_q[fifo_rd_q] : 32'd0;
    assign bus.instr_pc       = head_valid ? fifo_pc_q[fifo_rd_q] : '0;
    assign dbg_state_o        = state_q;
endmodule
